// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package riscv_fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous queue with push, pop and flush; the head entry is visible combinationally.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int CW = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full queue may still take a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!reset)
    !(push && full && !pop && !flush))
    else $error("fetch_fifo overflow");

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word fetches and
// buffers in-order responses for decode, dropping stale responses after a redirect.
module if_fetch_stage
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  localparam int CW = cnt_width(DEPTH);

  logic [31:0]  pc;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] tag_cnt;
  logic          run;
  logic          deq;
  logic          credit_ok;
  logic          req_hs;
  logic          rsp_keep;
  logic [CW:0]   inflight;
  logic [31:0]   tag_head;
  logic [63:0]   head_bits;
  fetch_entry_t  head_entry;
  fetch_entry_t  new_entry;

  assign deq       = id_valid & id_ready;
  assign inflight  = {1'b0, out_cnt} + {1'b0, cnt} - {{CW{1'b0}}, deq};
  assign credit_ok = inflight < (CW + 1)'(DEPTH);

  // run holds requests off until the first edge after reset release.
  assign imem_req_valid = run & credit_ok & ~redirect_valid;
  assign imem_req_addr  = pc;
  assign req_hs         = imem_req_valid & imem_req_ready;
  assign rsp_keep       = imem_rsp_valid & ~redirect_valid & (drop_cnt == '0);

  assign new_entry  = '{pc: tag_head, inst: imem_rsp_data};
  assign head_entry = fetch_entry_t'(head_bits);

  assign id_valid = (cnt != '0);
  assign id_inst  = id_valid ? head_entry.inst : NOP_INST;
  assign id_pc    = id_valid ? head_entry.pc   : 32'h0;

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_hs),
    .push_data (pc),
    .pop       (rsp_keep),
    .flush     (redirect_valid),
    .head      (tag_head),
    .count     (tag_cnt)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_entry_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rsp_keep),
    .push_data (new_entry),
    .pop       (deq),
    .flush     (redirect_valid),
    .head      (head_bits),
    .count     (cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC & ~32'd3;
      out_cnt  <= '0;
      drop_cnt <= '0;
      run      <= 1'b0;
    end else begin
      run     <= 1'b1;
      out_cnt <= out_cnt + CW'(req_hs) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        pc       <= redirect_pc & ~32'd3;
        // Everything of the old stream still in flight must be discarded.
        drop_cnt <= out_cnt - CW'(imem_rsp_valid);
      end else begin
        if (req_hs) pc <= pc + 32'd4;
        if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  // Each in-flight request either has a tag waiting or is scheduled for dropping.
  credit_chk: assert property (@(posedge clk) disable iff (!reset)
    (tag_cnt + drop_cnt) == out_cnt)
    else $error("if_fetch_stage tag/drop accounting broken");

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage: in-order memory model plus a stream-level
// reference (expected head PC, buffered count, outstanding requests per epoch).
module tb_if_fetch_stage;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  if_fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          epoch;
  int          buffered;
  int          cyc;
  int          checks;
  int          errors;
  int          rsp_pct;
  int          valid_cycles;
  bit          started;
  bit          prev_rdr;
  bit          force_rdr;
  logic [31:0] force_pc;
  logic [31:0] exp_head;
  logic [31:0] exp_req;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    buffered = 0;
    started  = 1'b0;
    prev_rdr = 1'b0;
    exp_req  = RESET_PC;
    exp_head = RESET_PC;
    epoch++;
  endtask

  // One call = n clock cycles; rdr is the redirect probability in per-mille.
  task automatic run(input int n, input int lat, input int rdy, input int idr, input int rdr);
    for (int i = 0; i < n; i++) begin
      bit          rv;
      bit          rd;
      bit          dq;
      bit          exp_rv;
      logic [31:0] tgt;
      imem_req_ready = ($urandom_range(99) < rdy);
      id_ready       = ($urandom_range(99) < idr);
      rv = (mq.size() > 0) && (mq[0].due <= cyc) && ($urandom_range(99) < rsp_pct);
      imem_rsp_valid = rv;
      imem_rsp_data  = rv ? mem_data(mq[0].addr) : $urandom;
      rd  = force_rdr || (!prev_rdr && ($urandom_range(999) < rdr));
      tgt = force_rdr ? force_pc : $urandom;
      force_rdr      = 1'b0;
      redirect_valid = rd;
      redirect_pc    = tgt;
      #1;
      dq     = (buffered > 0) && id_ready;
      exp_rv = started && !rd && ((mq.size() + buffered - int'(dq)) < DEPTH);
      chk("id_valid", {31'b0, id_valid}, {31'b0, buffered > 0});
      chk("id_pc",    id_pc,   (buffered > 0) ? exp_head : 32'h0);
      chk("id_inst",  id_inst, (buffered > 0) ? mem_data(exp_head) : NOP);
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
      chk("req_addr", imem_req_addr, exp_req);
      valid_cycles += int'(id_valid);
      if (exp_rv && imem_req_ready) begin
        mq.push_back('{exp_req, epoch, cyc + lat});
        exp_req += 32'd4;
      end
      if (rv) begin
        if (mq[0].epoch == epoch && !rd) buffered++;
        void'(mq.pop_front());
      end
      if (dq) begin
        buffered--;
        exp_head += 32'd4;
      end
      if (rd) begin
        epoch++;
        buffered = 0;
        exp_head = tgt & ~32'd3;
        exp_req  = tgt & ~32'd3;
      end
      started  = 1'b1;
      prev_rdr = rd;
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; epoch = 0; rsp_pct = 100; force_rdr = 1'b0;
    force_pc = '0; valid_cycles = 0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_req_addr",  imem_req_addr, RESET_PC);
    chk("rst_id_inst",   id_inst, NOP);
    chk("rst_id_pc",     id_pc, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Streaming at L=1: first valid three cycles after release, then one per cycle.
    valid_cycles = 0;
    run(20, 1, 100, 100, 0);
    chk("throughput", valid_cycles, 17);

    // Decode stall, then release.
    run(8, 1, 100, 0, 0);
    run(10, 1, 100, 100, 0);

    // Redirect while a response and a deq land in the same cycle.
    force_rdr = 1'b1; force_pc = 32'h0000_0200;
    run(8, 1, 100, 100, 0);

    // Long latency with two outstanding, redirect to 0x100.
    run(10, 3, 100, 100, 0);
    force_rdr = 1'b1; force_pc = 32'h0000_0100;
    run(15, 3, 100, 100, 0);

    // Unaligned target near the top of the address space wraps to zero.
    force_rdr = 1'b1; force_pc = 32'hFFFF_FFFE;
    run(10, 1, 100, 100, 0);

    for (int k = 0; k < 20; k++) begin
      rsp_pct = $urandom_range(40, 100);
      run(150, $urandom_range(1, 4), $urandom_range(30, 100), $urandom_range(20, 100),
          $urandom_range(0, 60));
    end
    rsp_pct = 100;

    // Build up outstanding/buffered state, then reset mid-cycle.
    run(6, 3, 100, 0, 0);
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("arst_req_addr",  imem_req_addr, RESET_PC);
    chk("arst_id_valid",  {31'b0, id_valid}, 32'h0);
    chk("arst_id_inst",   id_inst, NOP);
    chk("arst_id_pc",     id_pc, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    run(200, 2, 80, 70, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the RISC-V pipeline. It owns the PC, issues word requests to instruction memory over a valid/ready channel, and buffers in-order responses in a small queue. It presents {PC, instruction} pairs to the decode stage, where the instruction word drives the immediate generator and the decoder. It redirects on branch/jump resolution and discards stale in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- DEPTH, 2: instruction buffer entries. Also the limit on outstanding plus buffered fetches. Legal values are 2 to 8.
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address; bits [1:0] are always 0.
- imem_rsp_valid  in  1  response valid. Responses return in order, one per cycle maximum, at least 1 cycle after acceptance, and are never back-pressured.
- imem_rsp_data  in  32  fetched instruction.
- redirect_valid  in  1  branch/jump taken; from EX.
- redirect_pc  in  32  new PC. Bits [1:0] are ignored and treated as 00.
- id_valid  out  1  decode-side entry valid.
- id_ready  in  1  decode accepts entry; low when decode stalls.
- id_inst  out  32  instruction to decode. Equals NOP_INST whenever id_valid=0.
- id_pc  out  32  PC of id_inst. Equals 0 whenever id_valid=0.

## Operation
- State:
  - pc: next fetch address.
  - out_cnt: accepted requests with no response yet.
  - drop_cnt: responses still to be discarded.
  - buffer: queue of {pc, inst} entries, holding cnt entries.
- Derived signals:
  - deq = id_valid & id_ready.
  - credit_ok = (out_cnt + cnt − deq) < DEPTH.
- Request:
  - imem_req_valid = credit_ok & !redirect_valid.
  - imem_req_addr = pc.
  - On handshake: pc += 4 (modulo 2^32; wraps 0xFFFF_FFFC→0) and out_cnt += 1.
  - The pc of each accepted request is queued internally alongside the request. The pc-tag queue has DEPTH entries and shares the credit limit.
- Response:
  - Every imem_rsp_valid decrements out_cnt.
  - If drop_cnt>0, drop the response and decrement drop_cnt.
  - Otherwise enqueue {tag pc, imem_rsp_data}.
  - Credit accounting guarantees the buffer never overflows. An overflow is an assertion failure.
- Decode side:
  - id_valid = (cnt>0).
  - id_inst and id_pc show the head entry.
  - An entry leaves only on deq.
  - Outputs are held stable while id_valid & !id_ready.
- Redirect (single-cycle pulse):
  - pc ← {redirect_pc[31:2],2'b00}.
  - buffer and pc-tag queue are flushed (cnt ← 0).
  - drop_cnt ← out_cnt − imem_rsp_valid, i.e. every still-outstanding response of the old stream is dropped.
  - A response arriving in the redirect cycle is discarded.
  - A deq in the redirect cycle counts as consumed; flushing that instruction is decode's responsibility.
  - No request is issued in the redirect cycle.
- Simultaneous response and deq in the same cycle: the count nets correctly and throughput is unaffected.

## Timing
- Reset values (asynchronous):
  - pc=RESET_PC; out_cnt=drop_cnt=cnt=0.
  - imem_req_valid=0, imem_req_addr=RESET_PC.
  - id_valid=0, id_inst=NOP_INST, id_pc=0.
- First request is valid in the first clk edge-cycle after reset deasserts.
- Latency: response captured at edge E gives id_valid=1 after E. With memory latency L, request-accept to id_valid is L+1 cycles.
- Throughput: with L=1, DEPTH=2, imem_req_ready=1 and id_ready=1, the stage sustains one instruction per cycle.
- Redirect at edge E: the first request to the new pc is valid after E. id_valid is 0 after E until a new-stream response arrives.
- There is a combinational path id_ready → imem_req_valid. This is intended.
- Reset mid-operation drops all state immediately. Responses that arrive later belong to the memory's own reset domain and are not filtered.

## Structure
- Shared package riscv_fetch_pkg:
  - NOP_INST = 32'h0000_0013 (addi x0,x0,0).
  - typedef struct packed {logic [31:0] pc; logic [31:0] inst;} fetch_entry_t.
  - Counter width function $clog2(DEPTH+1).
- Sub-module fetch_fifo: parameterised synchronous queue with push, pop and flush. Instantiated twice, once for pc tags and once for fetch entries.
- Immediate generation and decode stay in the existing downstream blocks.

## Test plan
- Reset release, L=1, all ready: imem_req_addr = 0,4,8,… on consecutive cycles. id_pc 0,4,8 with matching id_inst, one per cycle. id_inst=0x00000013 before the first valid.
- id_ready low for 5 cycles: buffer fills to 2 and imem_req_valid drops. id_inst/id_pc stay stable. On release, no instruction is lost or duplicated.
- L=3, redirect to 0x100 with 2 requests outstanding: both old responses are dropped. The next id_pc=0x100 and the next request address is 0x104.
- Redirect in the same cycle as a response and a deq: the response is discarded, drop_cnt=out_cnt−1, and no request is issued that cycle.
- redirect_pc=0xFFFF_FFFE: the fetch address is 0xFFFF_FFFC, then 0x0000_0000.
- Reset asserted with 2 requests outstanding and cnt=1: all outputs return to reset values asynchronously, before the next clk edge.
